// File: rtl/counter_tick_ctrl.sv
// Rate/control stage for the 0-9 bidirectional counter: debounced run/step buttons,
// four selectable tick rates and a one-cycle registered enable pulse.
module counter_tick_ctrl #(
  parameter int BASE_DIV  = 50_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       clki,
  input  logic       reset_n,
  input  logic       btn_run,
  input  logic       btn_step,
  input  logic [1:0] speed_sel,
  output logic       enable,
  output logic       running
);

  localparam int PW = $clog2(BASE_DIV);
  localparam int DW = $clog2(DB_CYCLES);

  localparam logic [PW-1:0] LIM0_M1 = PW'(BASE_DIV - 1);
  localparam logic [PW-1:0] LIM1_M1 = PW'(BASE_DIV / 2 - 1);
  localparam logic [PW-1:0] LIM2_M1 = PW'(BASE_DIV / 4 - 1);
  localparam logic [PW-1:0] LIM3_M1 = PW'(BASE_DIV / 8 - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_RUNNING = 1'b0,
    ST_PAUSED  = 1'b1
  } state_t;

  // Button index 0 is run/pause, index 1 is single-step.
  logic [1:0]    btn_raw_s;
  logic [1:0]    sync1_q;
  logic [1:0]    sync2_q;
  logic [1:0]    spd_sync1_q;
  logic [1:0]    spd_q;
  logic [DW-1:0] db_cnt_q [2];
  logic [DW-1:0] db_cnt_d [2];
  logic [1:0]    db_lvl_q;
  logic [1:0]    db_lvl_d;
  logic [1:0]    db_prev_q;
  logic [1:0]    press_s;
  logic          run_press_s;
  logic          step_press_s;
  logic [PW-1:0] limit_m1_s;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  state_t        state_q;
  state_t        state_d;
  logic          enable_q;
  logic          enable_d;

  assign btn_raw_s = {btn_step, btn_run};

  always_ff @(posedge clki or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 2'b00;
      sync2_q     <= 2'b00;
      spd_sync1_q <= 2'b00;
      spd_q       <= 2'b00;
    end else begin
      sync1_q     <= btn_raw_s;
      sync2_q     <= sync1_q;
      spd_sync1_q <= speed_sel;
      spd_q       <= spd_sync1_q;
    end
  end

  // A level is accepted only after DB_CYCLES consecutive differing samples.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      db_lvl_d[i] = db_lvl_q[i];
      if (sync2_q[i] == db_lvl_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_lvl_d[i] = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DW'(1);
      end
    end
  end

  always_ff @(posedge clki or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= '0;
      end
      db_lvl_q  <= 2'b00;
      db_prev_q <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      db_lvl_q  <= db_lvl_d;
      db_prev_q <= db_lvl_q;
    end
  end

  assign press_s      = db_lvl_q & ~db_prev_q;
  assign run_press_s  = press_s[0];
  assign step_press_s = press_s[1];

  always_comb begin
    limit_m1_s = LIM0_M1;
    case (spd_q)
      2'd0:    limit_m1_s = LIM0_M1;
      2'd1:    limit_m1_s = LIM1_M1;
      2'd2:    limit_m1_s = LIM2_M1;
      2'd3:    limit_m1_s = LIM3_M1;
      default: limit_m1_s = LIM0_M1;
    endcase
  end

  // Terminal compare uses >= so a mid-period switch to a faster rate ticks at most once early.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    enable_d = 1'b0;
    case (state_q)
      ST_RUNNING: begin
        if (run_press_s) begin
          state_d = ST_PAUSED;
          presc_d = '0;
        end else if (presc_q >= limit_m1_s) begin
          presc_d  = '0;
          enable_d = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      ST_PAUSED: begin
        presc_d = '0;
        if (run_press_s) begin
          state_d = ST_RUNNING;
        end else if (step_press_s) begin
          enable_d = 1'b1;
        end else begin
          enable_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_RUNNING;
        presc_d = '0;
      end
    endcase
  end

  always_ff @(posedge clki or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RUNNING;
      presc_q  <= '0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      enable_q <= enable_d;
    end
  end

  assign enable  = enable_q;
  assign running = (state_q == ST_RUNNING);

endmodule

// File: tb/tb_counter_tick_ctrl.sv
// Directed bench for counter_tick_ctrl with BASE_DIV=16 and DB_CYCLES=4.
module tb_counter_tick_ctrl;

  localparam int BASE_DIV  = 16;
  localparam int DB_CYCLES = 4;

  logic       clki      = 1'b0;
  logic       reset_n   = 1'b0;
  logic       btn_run   = 1'b0;
  logic       btn_step  = 1'b0;
  logic [1:0] speed_sel = 2'd0;
  logic       enable;
  logic       running;

  int checks = 0;
  int errors = 0;

  always #5 clki = ~clki;

  counter_tick_ctrl #(
    .BASE_DIV (BASE_DIV),
    .DB_CYCLES(DB_CYCLES)
  ) dut (
    .clki     (clki),
    .reset_n  (reset_n),
    .btn_run  (btn_run),
    .btn_step (btn_step),
    .speed_sel(speed_sel),
    .enable   (enable),
    .running  (running)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clki);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Edges until enable is seen high; returns limit on timeout.
  task automatic wait_pulse(input int limit, output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (enable !== 1'b1 && n < limit);
  endtask

  // Count enable-high samples over n edges and note the first one.
  task automatic count_window(input int n, output int cnt, output int first);
    cnt   = 0;
    first = 0;
    for (int i = 1; i <= n; i++) begin
      tick(1);
      if (enable === 1'b1) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
  endtask

  initial begin
    int n;
    int cnt;
    int first;

    // Reset state
    tick(3);
    check("rst_running", int'(running), 1);
    check("rst_enable", int'(enable), 0);
    reset_n = 1'b1;
    wait_pulse(100, n);
    check("first_pulse_16", n, 16);
    wait_pulse(100, n);
    check("period_16", n, 16);

    // Fastest rate, then back to the slowest mid-period
    speed_sel = 2'd3;
    wait_pulse(100, n);
    check("spd3_transition", n, 3);
    wait_pulse(100, n);
    check("spd3_period_a", n, 2);
    wait_pulse(100, n);
    check("spd3_period_b", n, 2);
    speed_sel = 2'd0;
    wait_pulse(100, n);
    check("spd0_transition", n, 2);
    wait_pulse(100, n);
    check("spd0_period", n, 16);

    // Short glitch is rejected, long press pauses
    btn_run = 1'b1;
    tick(3);
    btn_run = 1'b0;
    tick(10);
    check("glitch_running", int'(running), 1);
    btn_run = 1'b1;
    tick(6);
    check("run_before_accept", int'(running), 1);
    tick(1);
    check("paused_at_7", int'(running), 0);
    tick(3);
    btn_run = 1'b0;
    count_window(40, cnt, first);
    check("paused_no_ticks", cnt, 0);

    // Three single steps
    for (int k = 0; k < 3; k++) begin
      btn_step = 1'b1;
      count_window(10, cnt, first);
      check("step_count", cnt, 1);
      check("step_latency", first, 7);
      btn_step = 1'b0;
      count_window(10, cnt, first);
      check("step_release", cnt, 0);
    end

    // Resume: first tick 16 cycles after the transition at edge 7
    btn_run = 1'b1;
    tick(6);
    check("still_paused", int'(running), 0);
    tick(1);
    check("resumed_at_7", int'(running), 1);
    tick(3);
    btn_run = 1'b0;
    wait_pulse(100, n);
    check("resume_first", n, 13);
    wait_pulse(100, n);
    check("resume_period", n, 16);

    // Pause, then run and step together: run wins, no step pulse
    btn_run = 1'b1;
    tick(10);
    btn_run = 1'b0;
    tick(20);
    check("paused_again", int'(running), 0);
    btn_run  = 1'b1;
    btn_step = 1'b1;
    count_window(10, cnt, first);
    btn_run  = 1'b0;
    btn_step = 1'b0;
    check("simul_running", int'(running), 1);
    check("simul_no_step", cnt, 0);
    wait_pulse(100, n);
    check("simul_first_tick", n, 13);

    // Reset while paused restores RUNNING immediately
    btn_run = 1'b1;
    tick(10);
    btn_run = 1'b0;
    tick(10);
    check("pre_reset_paused", int'(running), 0);
    reset_n = 1'b0;
    #1;
    check("async_rst_running", int'(running), 1);
    tick(2);
    reset_n = 1'b1;
    wait_pulse(100, n);
    check("post_rst_pulse_a", n, 16);

    // Reset mid-debounce and mid-prescale with enable high
    tick(11);
    btn_run = 1'b1;
    tick(5);
    check("pre_reset_tick", int'(enable), 1);
    reset_n = 1'b0;
    btn_run = 1'b0;
    #1;
    check("async_rst_enable", int'(enable), 0);
    check("async_rst_run2", int'(running), 1);
    tick(2);
    reset_n = 1'b1;
    wait_pulse(100, n);
    check("post_rst_pulse_b", n, 16);
    tick(4);
    check("post_rst_running", int'(running), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
